// File: rtl/i2c_mem_slave.sv
// I2C target fronting a 128x8 register memory with pointer auto-increment.
// Define I2C_SLV_STRETCH_EN to hold SCL low for STRETCH_CYC clks after each ACK and read load.
module i2c_mem_slave #(
    parameter logic [6:0] DEV_ADDR    = 7'h50,
    parameter int         STRETCH_CYC = 250
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire        scl,
    inout  wire        sda,
    output logic       busy,
    output logic       wr_pulse,
    output logic       rd_pulse,
    output logic       nack_rcvd,
    output logic [6:0] cur_ptr
);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        WAIT_STOP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [6:0]  ptr_q, ptr_d;
    logic        rw_q, rw_d;
    logic        busy_q, busy_d;
    logic        sda_low_q, sda_low_d;
    logic        wr_q, wr_d;
    logic        rd_q, rd_d;
    logic        nack_q, nack_d;
    logic        mem_we;
    logic        st_go;
    logic [7:0]  rx_byte;
    logic [7:0]  rdata_q;
    logic [7:0]  mem_q [128];

    logic [1:0]  scl_s_q, sda_s_q;
    logic        scl_p_q, sda_p_q;
    logic        scl_rise, scl_fall;
    logic        start_c, stop_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_s_q <= 2'b11;
            sda_s_q <= 2'b11;
            scl_p_q <= 1'b1;
            sda_p_q <= 1'b1;
        end else begin
            scl_s_q <= {scl_s_q[0], scl};
            sda_s_q <= {sda_s_q[0], sda};
            scl_p_q <= scl_s_q[1];
            sda_p_q <= sda_s_q[1];
        end
    end

    assign scl_rise = scl_s_q[1] & ~scl_p_q;
    assign scl_fall = ~scl_s_q[1] & scl_p_q;
    assign start_c  = scl_s_q[1] & scl_p_q & sda_p_q & ~sda_s_q[1];
    assign stop_c   = scl_s_q[1] & scl_p_q & ~sda_p_q & sda_s_q[1];

    // Single port: a write cycle suppresses the registered read.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[ptr_q] <= rx_byte;
        end else begin
            rdata_q <= mem_q[ptr_q];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            rw_q      <= 1'b0;
            busy_q    <= 1'b0;
            sda_low_q <= 1'b0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            nack_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            rw_q      <= rw_d;
            busy_q    <= busy_d;
            sda_low_q <= sda_low_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            nack_q    <= nack_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        rw_d      = rw_q;
        busy_d    = busy_q;
        sda_low_d = sda_low_q;
        wr_d      = 1'b0;
        rd_d      = 1'b0;
        nack_d    = 1'b0;
        mem_we    = 1'b0;
        st_go     = 1'b0;
        rx_byte   = {shift_q[6:0], sda_s_q[1]};
        if (start_c) begin
            state_d   = ADDR;
            cnt_d     = '0;
            busy_d    = 1'b0;
            sda_low_d = 1'b0;
        end else if (stop_c) begin
            state_d   = IDLE;
            cnt_d     = '0;
            busy_d    = 1'b0;
            sda_low_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, WAIT_STOP: ;
                ADDR: if (scl_rise) begin
                    shift_d = rx_byte;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d = '0;
                        if (rx_byte[7:1] == DEV_ADDR) begin
                            state_d = ADDR_ACK;
                            busy_d  = 1'b1;
                            rw_d    = rx_byte[0];
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end
                end
                PTR: if (scl_rise) begin
                    shift_d = rx_byte;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d   = '0;
                        ptr_d   = rx_byte[6:0];
                        state_d = PTR_ACK;
                    end
                end
                WR_DATA: if (scl_rise) begin
                    shift_d = rx_byte;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d   = '0;
                        mem_we  = 1'b1;
                        wr_d    = 1'b1;
                        ptr_d   = ptr_q + 7'd1;
                        state_d = WR_ACK;
                    end
                end
                ADDR_ACK, PTR_ACK, WR_ACK: if (scl_fall) begin
                    if (cnt_q == 4'd0) begin
                        sda_low_d = 1'b1;
                        cnt_d     = 4'd1;
                    end else begin
                        cnt_d     = '0;
                        sda_low_d = 1'b0;
                        st_go     = 1'b1;
                        if (state_q == ADDR_ACK && rw_q) begin
                            shift_d   = rdata_q;
                            sda_low_d = ~rdata_q[7];
                            rd_d      = 1'b1;
                            ptr_d     = ptr_q + 7'd1;
                            state_d   = RD_DATA;
                        end else if (state_q == ADDR_ACK) begin
                            state_d = PTR;
                        end else begin
                            state_d = WR_DATA;
                        end
                    end
                end
                RD_DATA: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            cnt_d     = '0;
                            sda_low_d = 1'b0;
                            state_d   = RD_ACK;
                        end else begin
                            shift_d   = {shift_q[6:0], 1'b0};
                            sda_low_d = ~shift_q[6];
                        end
                    end
                end
                // ptr was post-incremented at load, so it already names the next byte.
                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s_q[1]) begin
                            nack_d  = 1'b1;
                            state_d = WAIT_STOP;
                        end else begin
                            cnt_d = 4'd1;
                        end
                    end else if (scl_fall && cnt_q == 4'd1) begin
                        cnt_d     = '0;
                        st_go     = 1'b1;
                        shift_d   = rdata_q;
                        sda_low_d = ~rdata_q[7];
                        rd_d      = 1'b1;
                        ptr_d     = ptr_q + 7'd1;
                        state_d   = RD_DATA;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign sda       = sda_low_q ? 1'b0 : 1'bz;
    assign busy      = busy_q;
    assign wr_pulse  = wr_q;
    assign rd_pulse  = rd_q;
    assign nack_rcvd = nack_q;
    assign cur_ptr   = ptr_q;

`ifdef I2C_SLV_STRETCH_EN
    localparam int StrW = $clog2(STRETCH_CYC + 1);
    logic [StrW-1:0] str_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            str_q <= '0;
        end else if (st_go) begin
            str_q <= StrW'(STRETCH_CYC);
        end else if (str_q != '0) begin
            str_q <= str_q - StrW'(1);
        end
    end

    assign scl = (str_q != '0) ? 1'b0 : 1'bz;
`else
    logic unused_stretch;
    assign unused_stretch = ^{st_go, STRETCH_CYC};
`endif

endmodule

// File: tb/tb_i2c_mem_slave.sv
// Scoreboard bench for i2c_mem_slave: bit-banged master, pulse monitor.
module tb_i2c_mem_slave;

    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       scl_drv = 1'b0;
    logic       sda_drv = 1'b0;
    wire        scl_bus;
    wire        sda_bus;
    logic       busy, wr_pulse, rd_pulse, nack_rcvd;
    logic [6:0] cur_ptr;

    assign scl_bus = scl_drv ? 1'b0 : 1'bz;
    assign sda_bus = sda_drv ? 1'b0 : 1'bz;
    pullup (scl_bus);
    pullup (sda_bus);

    i2c_mem_slave dut (
        .clk      (clk),
        .rst      (rst),
        .scl      (scl_bus),
        .sda      (sda_bus),
        .busy     (busy),
        .wr_pulse (wr_pulse),
        .rd_pulse (rd_pulse),
        .nack_rcvd(nack_rcvd),
        .cur_ptr  (cur_ptr)
    );

    always #10 clk = ~clk;

    int         nchk = 0;
    int         nerr = 0;
    int         tgt_low = 0;
    int         low_len = 0;
    int         n_str = 0;
    bit         busy_seen = 1'b0;
    logic [6:0] exp_wr[$];
    logic [6:0] exp_rd[$];
    logic [6:0] exp_nack[$];

    task automatic check(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic unexp(input string nm);
        nchk++;
        nerr++;
        $display("FAIL %s: pulse with nothing expected", nm);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (wr_pulse) begin
                if (exp_wr.size() == 0) unexp("wr_pulse");
                else check("wr_ptr", cur_ptr, exp_wr.pop_front());
            end
            if (rd_pulse) begin
                if (exp_rd.size() == 0) unexp("rd_pulse");
                else check("rd_ptr", cur_ptr, exp_rd.pop_front());
            end
            if (nack_rcvd) begin
                if (exp_nack.size() == 0) unexp("nack_rcvd");
                else check("nack_ptr", cur_ptr, exp_nack.pop_front());
            end
            if (busy) busy_seen = 1'b1;
            if (sda_bus === 1'b0 && !sda_drv) tgt_low++;
        end
        if (scl_bus === 1'b0) begin
            low_len++;
        end else begin
`ifdef I2C_SLV_STRETCH_EN
            if (low_len > 100) begin
                n_str++;
                check("stretch_ok", int'(low_len >= 248 && low_len <= 256), 1);
            end
`endif
            low_len = 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic scl_up();
        int n = 0;
        scl_drv = 1'b0;
        while (scl_bus !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            nchk++;
            nerr++;
            $display("FAIL scl_timeout: got low want high");
        end
    endtask

    task automatic clk_bit(input bit b, output bit r);
        tick(Q);
        sda_drv = ~b;
        tick(Q);
        scl_up();
        tick(Q);
        r = sda_bus;
        tick(Q);
        scl_drv = 1'b1;
    endtask

    task automatic wr_byte(input logic [7:0] d, output bit ack);
        bit r;
        for (int i = 7; i >= 0; i--) clk_bit(d[i], r);
        clk_bit(1'b1, ack);
    endtask

    task automatic rd_byte(input bit nack, output logic [7:0] d);
        bit r;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, r);
            d[i] = r;
        end
        clk_bit(nack, r);
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1;
        tick(Q);
        scl_drv = 1'b1;
    endtask

    task automatic i2c_rstart();
        tick(Q);
        sda_drv = 1'b0;
        tick(Q);
        scl_up();
        tick(Q);
        sda_drv = 1'b1;
        tick(Q);
        scl_drv = 1'b1;
    endtask

    task automatic i2c_stop();
        tick(Q);
        sda_drv = 1'b1;
        tick(Q);
        scl_up();
        tick(Q);
        sda_drv = 1'b0;
        tick(2 * Q);
    endtask

    task automatic wr_ack(input string nm, input logic [7:0] d);
        bit a;
        wr_byte(d, a);
        check(nm, a, 0);
    endtask

    task automatic q_empty(input string nm);
        check({nm, "_q"}, exp_wr.size() + exp_rd.size() + exp_nack.size(), 0);
    endtask

    initial begin
        logic [7:0] d;
        bit         a;

        tick(5);
        check("rst_busy", busy, 0);
        check("rst_pulses", {wr_pulse, rd_pulse, nack_rcvd}, 0);
        check("rst_ptr", cur_ptr, 0);
        check("rst_sda", sda_bus, 1);
        check("rst_scl", scl_bus, 1);
        rst = 1'b1;
        tick(5);

        exp_wr.push_back(7'h11);
        i2c_start();
        wr_ack("w_addr_ack", 8'hA0);
        check("w_busy", busy, 1);
        wr_ack("w_ptr_ack", 8'h10);
        wr_ack("w_dat_ack", 8'hA5);
        i2c_stop();
        check("w_ptr", cur_ptr, 7'h11);
        check("w_busy_stop", busy, 0);
        q_empty("w");

        exp_rd.push_back(7'h11);
        exp_nack.push_back(7'h11);
        i2c_start();
        wr_ack("rr_addr_ack", 8'hA0);
        wr_ack("rr_ptr_ack", 8'h10);
        i2c_rstart();
        wr_ack("rr_raddr_ack", 8'hA1);
        rd_byte(1'b1, d);
        check("rr_data", d, 8'hA5);
        i2c_stop();
        check("rr_ptr", cur_ptr, 7'h11);
        q_empty("rr");

        exp_wr.push_back(7'h00);
        exp_wr.push_back(7'h01);
        i2c_start();
        wr_ack("wr_addr_ack", 8'hA0);
        wr_ack("wr_ptr_ack", 8'h7F);
        wr_ack("wr_d0_ack", 8'h11);
        wr_ack("wr_d1_ack", 8'h22);
        i2c_stop();
        check("wrap_wptr", cur_ptr, 7'h01);
        exp_rd.push_back(7'h00);
        exp_rd.push_back(7'h01);
        exp_nack.push_back(7'h01);
        i2c_start();
        wr_ack("br_addr_ack", 8'hA0);
        wr_ack("br_ptr_ack", 8'h7F);
        i2c_rstart();
        wr_ack("br_raddr_ack", 8'hA1);
        rd_byte(1'b0, d);
        check("br_d0", d, 8'h11);
        rd_byte(1'b1, d);
        check("br_d1", d, 8'h22);
        i2c_stop();
        check("wrap_rptr", cur_ptr, 7'h01);
        q_empty("wrap");

        tgt_low = 0;
        busy_seen = 1'b0;
        i2c_start();
        wr_byte(8'hA2, a);
        check("mm_addr_nack", a, 1);
        wr_byte(8'hFF, a);
        check("mm_data_nack", a, 1);
        i2c_stop();
        check("mm_sda_low", tgt_low, 0);
        check("mm_busy", busy_seen, 0);
        check("mm_ptr", cur_ptr, 7'h01);

        exp_wr.push_back(7'h21);
        i2c_start();
        wr_ack("ab_addr_ack", 8'hA0);
        wr_ack("ab_ptr_ack", 8'h20);
        wr_ack("ab_pre_ack", 8'h5A);
        i2c_stop();
        i2c_start();
        wr_ack("ab_addr2_ack", 8'hA0);
        wr_ack("ab_ptr2_ack", 8'h20);
        clk_bit(1'b1, a);
        clk_bit(1'b1, a);
        clk_bit(1'b0, a);
        clk_bit(1'b0, a);
        i2c_stop();
        check("ab_ptr", cur_ptr, 7'h20);
        check("ab_busy", busy, 0);
        exp_rd.push_back(7'h21);
        exp_nack.push_back(7'h21);
        i2c_start();
        wr_ack("ab_addr3_ack", 8'hA0);
        wr_ack("ab_ptr3_ack", 8'h20);
        i2c_rstart();
        wr_ack("ab_raddr_ack", 8'hA1);
        rd_byte(1'b1, d);
        check("ab_data", d, 8'h5A);
        i2c_stop();
        q_empty("ab");

`ifdef I2C_SLV_STRETCH_EN
        n_str = 0;
        exp_wr.push_back(7'h06);
        i2c_start();
        wr_ack("st_addr_ack", 8'hA0);
        wr_ack("st_ptr_ack", 8'h05);
        wr_ack("st_dat_ack", 8'h3C);
        i2c_stop();
        check("st_count", n_str, 3);
        exp_rd.push_back(7'h06);
        exp_nack.push_back(7'h06);
        i2c_start();
        wr_ack("st_addr2_ack", 8'hA0);
        wr_ack("st_ptr2_ack", 8'h05);
        i2c_rstart();
        wr_ack("st_raddr_ack", 8'hA1);
        rd_byte(1'b1, d);
        check("st_data", d, 8'h3C);
        i2c_stop();
        q_empty("st");
`endif

        exp_rd.push_back(7'h11);
        i2c_start();
        wr_ack("rs_addr_ack", 8'hA0);
        wr_ack("rs_ptr_ack", 8'h10);
        i2c_rstart();
        wr_ack("rs_raddr_ack", 8'hA1);
        clk_bit(1'b1, a);
        check("rs_msb", a, 1);
        tick(6);
        check("rs_drive_low", sda_bus, 0);
        rst = 1'b0;
        #1;
        check("rs_sda_rel", sda_bus, 1);
        check("rs_busy", busy, 0);
        check("rs_ptr", cur_ptr, 0);
        check("rs_pulses", {wr_pulse, rd_pulse, nack_rcvd}, 0);
        tick(3);
        rst = 1'b1;
        i2c_stop();
        check("rs_busy_end", busy, 0);
        q_empty("rs");

        tick(10);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
